// File: rtl/ps2_key_decoder.sv
// PS/2 set-2 keyboard receiver: conditions ps2c/ps2d, frames 11-bit words, and decodes
// make/break codes with E0 extension into the last make code plus arrow-key held flags.
module ps2_key_decoder #(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 200000
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        ps2c,
  input  logic        ps2d,
  output logic [15:0] xkey,
  output logic        key_valid,
  output logic [3:0]  key_hold,
  output logic        frame_err
);

  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {StIdle, StShift, StCheck} state_e;

  // Input synchronizers; idle level of both PS/2 lines is high.
  logic c_meta_q, c_sync_q, d_meta_q, d_sync_q;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      c_meta_q <= 1'b1;
      c_sync_q <= 1'b1;
      d_meta_q <= 1'b1;
      d_sync_q <= 1'b1;
    end else begin
      c_meta_q <= ps2c;
      c_sync_q <= c_meta_q;
      d_meta_q <= ps2d;
      d_sync_q <= d_meta_q;
    end
  end

  // Glitch filter: the filtered clock only moves once every sample in the window agrees.
  logic [FILTER_LEN-1:0] filt_sr_q, filt_sr_d;
  logic                  filt_q, filt_d;
  logic                  fall;

  always_comb begin
    filt_sr_d = {filt_sr_q[FILTER_LEN-2:0], c_sync_q};
    filt_d    = filt_q;
    if (&filt_sr_q) begin
      filt_d = 1'b1;
    end else if (~|filt_sr_q) begin
      filt_d = 1'b0;
    end
    fall = filt_q & ~filt_d;
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      filt_sr_q <= '1;
      filt_q    <= 1'b1;
    end else begin
      filt_sr_q <= filt_sr_d;
      filt_q    <= filt_d;
    end
  end

  // Frame FSM. sr_q collects d0..d7, parity, stop with stop ending in the MSB.
  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [9:0]      sr_q, sr_d;
  logic [TmoW-1:0] tmo_q, tmo_d;
  logic            byte_ok;
  logic            frame_bad;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sr_d      = sr_q;
    tmo_d     = tmo_q;
    byte_ok   = 1'b0;
    frame_bad = 1'b0;
    unique case (state_q)
      StIdle: begin
        // A high start bit is treated as line noise and silently ignored.
        if (fall && !d_sync_q) begin
          state_d = StShift;
          cnt_d   = 4'd0;
          tmo_d   = '0;
        end
      end
      StShift: begin
        if (fall) begin
          sr_d  = {d_sync_q, sr_q[9:1]};
          cnt_d = cnt_q + 4'd1;
          tmo_d = '0;
          if (cnt_q == 4'd9) begin
            state_d = StCheck;
          end
        end else if (tmo_q == TmoW'(TIMEOUT_CYCLES)) begin
          frame_bad = 1'b1;
          state_d   = StIdle;
        end else begin
          tmo_d = tmo_q + TmoW'(1);
        end
      end
      StCheck: begin
        // Good frame: stop bit high and odd parity over data plus parity bit.
        if (sr_q[9] && (^sr_q[8:0])) begin
          byte_ok = 1'b1;
        end else begin
          frame_bad = 1'b1;
        end
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      sr_q    <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      tmo_q   <= tmo_d;
    end
  end

  // Scan-code decoder.
  logic        ext_q, ext_d;
  logic        brk_q, brk_d;
  logic [15:0] xkey_q, xkey_d;
  logic [3:0]  hold_q, hold_d;
  logic        key_valid_q, key_valid_d;
  logic        frame_err_q, frame_err_d;
  logic [7:0]  rx_byte;
  logic [15:0] code;
  logic [3:0]  arrow_mask;

  always_comb begin
    rx_byte = sr_q[7:0];
    code    = {ext_q ? 8'hE0 : 8'h00, rx_byte};
    case (code)
      16'hE075: arrow_mask = 4'b0001;
      16'hE072: arrow_mask = 4'b0010;
      16'hE06B: arrow_mask = 4'b0100;
      16'hE074: arrow_mask = 4'b1000;
      default:  arrow_mask = 4'b0000;
    endcase
  end

  always_comb begin
    ext_d       = ext_q;
    brk_d       = brk_q;
    xkey_d      = xkey_q;
    hold_d      = hold_q;
    key_valid_d = 1'b0;
    frame_err_d = 1'b0;
    if (frame_bad) begin
      // A corrupted frame may have been the code a prefix was waiting for.
      ext_d       = 1'b0;
      brk_d       = 1'b0;
      frame_err_d = 1'b1;
    end else if (byte_ok) begin
      if (rx_byte == 8'hE0) begin
        ext_d = 1'b1;
      end else if (rx_byte == 8'hF0) begin
        brk_d = 1'b1;
      end else begin
        if (!brk_q) begin
          xkey_d      = code;
          key_valid_d = 1'b1;
          hold_d      = hold_q | arrow_mask;
        end else begin
          hold_d = hold_q & ~arrow_mask;
        end
        ext_d = 1'b0;
        brk_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      ext_q       <= 1'b0;
      brk_q       <= 1'b0;
      xkey_q      <= 16'h0000;
      hold_q      <= 4'b0000;
      key_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      ext_q       <= ext_d;
      brk_q       <= brk_d;
      xkey_q      <= xkey_d;
      hold_q      <= hold_d;
      key_valid_q <= key_valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign xkey      = xkey_q;
  assign key_valid = key_valid_q;
  assign key_hold  = hold_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Bench for ps2_key_decoder: directed scenarios plus random scan-code streams compared
// against a byte-level keyboard model.
module tb_ps2_key_decoder;

  localparam int unsigned Filt = 8;
  localparam int unsigned Tmo  = 2000;
  localparam int          Half = 20;

  logic        clk = 1'b0;
  logic        clr;
  logic        ps2c;
  logic        ps2d;
  logic [15:0] xkey;
  logic        key_valid;
  logic [3:0]  key_hold;
  logic        frame_err;

  int n_chk  = 0;
  int n_fail = 0;
  int kv_cnt = 0;
  int fe_cnt = 0;

  // Reference model state.
  bit          m_ext, m_brk;
  logic [15:0] m_xkey;
  logic [3:0]  m_hold;
  int          exp_kv, exp_fe;

  ps2_key_decoder #(
    .FILTER_LEN    (Filt),
    .TIMEOUT_CYCLES(Tmo)
  ) dut (
    .clk      (clk),
    .clr      (clr),
    .ps2c     (ps2c),
    .ps2d     (ps2d),
    .xkey     (xkey),
    .key_valid(key_valid),
    .key_hold (key_hold),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (key_valid === 1'b1) kv_cnt++;
    if (frame_err === 1'b1) fe_cnt++;
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: time limit reached, got %0d checks, required completion", n_chk);
    $fatal(1);
  end

  function automatic logic [3:0] arrow_bit(input logic [15:0] c);
    if (c == 16'hE075) return 4'b0001;
    if (c == 16'hE072) return 4'b0010;
    if (c == 16'hE06B) return 4'b0100;
    if (c == 16'hE074) return 4'b1000;
    return 4'b0000;
  endfunction

  // Keyboard protocol model: one call per received frame (good=0 for any framing error).
  task automatic model_byte(input logic [7:0] b, input bit good);
    logic [15:0] c;
    if (!good) begin
      m_ext = 0;
      m_brk = 0;
      exp_fe++;
    end else if (b == 8'hE0) begin
      m_ext = 1;
    end else if (b == 8'hF0) begin
      m_brk = 1;
    end else begin
      c = {(m_ext ? 8'hE0 : 8'h00), b};
      if (!m_brk) begin
        m_xkey = c;
        exp_kv++;
        m_hold = m_hold | arrow_bit(c);
      end else begin
        m_hold = m_hold & ~arrow_bit(c);
      end
      m_ext = 0;
      m_brk = 0;
    end
  endtask

  task automatic send_bit(input logic v);
    @(negedge clk);
    ps2d = v;
    repeat (Half) @(negedge clk);
    ps2c = 1'b0;
    repeat (Half) @(negedge clk);
    ps2c = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    logic [10:0] f;
    f = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < 11; i++) send_bit(f[i]);
    repeat (12) @(negedge clk);
  endtask

  task automatic send_good(input logic [7:0] b);
    send_frame(b, 1'b0, 1'b0);
    model_byte(b, 1'b1);
  endtask

  task automatic test_reset;
    clr  = 1'b1;
    ps2c = 1'b1;
    ps2d = 1'b1;
    m_ext = 0; m_brk = 0; m_xkey = '0; m_hold = '0; exp_kv = 0; exp_fe = 0;
    repeat (3) @(negedge clk);
    n_chk++; if (xkey !== 16'h0000) begin n_fail++; $display("FAIL reset_xkey: got %h want 0000", xkey); end
    n_chk++; if (key_valid !== 1'b0) begin n_fail++; $display("FAIL reset_kv: got %b want 0", key_valid); end
    n_chk++; if (key_hold !== 4'b0) begin n_fail++; $display("FAIL reset_hold: got %b want 0000", key_hold); end
    n_chk++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_ferr: got %b want 0", frame_err); end
    clr = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_make;
    int kv0 = kv_cnt;
    int fe0 = fe_cnt;
    send_good(8'h1C);
    n_chk++; if (kv_cnt - kv0 !== 1) begin n_fail++; $display("FAIL make_kv: got %0d pulses want 1", kv_cnt - kv0); end
    n_chk++; if (xkey !== 16'h001C) begin n_fail++; $display("FAIL make_xkey: got %h want 001c", xkey); end
    n_chk++; if (key_hold !== 4'b0000) begin n_fail++; $display("FAIL make_hold: got %b want 0000", key_hold); end
    n_chk++; if (fe_cnt !== fe0) begin n_fail++; $display("FAIL make_ferr: got %0d want %0d", fe_cnt, fe0); end
  endtask

  task automatic test_break;
    int kv0;
    send_good(8'hE0);
    send_good(8'h75);
    n_chk++; if (xkey !== 16'hE075) begin n_fail++; $display("FAIL up_xkey: got %h want e075", xkey); end
    n_chk++; if (key_hold !== 4'b0001) begin n_fail++; $display("FAIL up_hold: got %b want 0001", key_hold); end
    kv0 = kv_cnt;
    send_good(8'hE0);
    send_good(8'hF0);
    send_good(8'h75);
    n_chk++; if (key_hold !== 4'b0000) begin n_fail++; $display("FAIL upbrk_hold: got %b want 0000", key_hold); end
    n_chk++; if (kv_cnt !== kv0) begin n_fail++; $display("FAIL upbrk_kv: got %0d want %0d", kv_cnt, kv0); end
    n_chk++; if (xkey !== 16'hE075) begin n_fail++; $display("FAIL upbrk_xkey: got %h want e075", xkey); end
  endtask

  task automatic test_multi_hold;
    send_good(8'hE0); send_good(8'h6B);
    n_chk++; if (key_hold !== 4'b0100) begin n_fail++; $display("FAIL multi_left: got %b want 0100", key_hold); end
    send_good(8'hE0); send_good(8'h74);
    n_chk++; if (key_hold !== 4'b1100) begin n_fail++; $display("FAIL multi_right: got %b want 1100", key_hold); end
    send_good(8'hE0); send_good(8'h74);
    n_chk++; if (key_hold !== 4'b1100) begin n_fail++; $display("FAIL multi_repeat: got %b want 1100", key_hold); end
    send_good(8'hE0); send_good(8'hF0); send_good(8'h6B);
    n_chk++; if (key_hold !== 4'b1000) begin n_fail++; $display("FAIL multi_relleft: got %b want 1000", key_hold); end
    n_chk++; if (kv_cnt !== exp_kv) begin n_fail++; $display("FAIL multi_kv: got %0d want %0d", kv_cnt, exp_kv); end
  endtask

  task automatic test_parity_err;
    int fe0 = fe_cnt;
    send_frame(8'h29, 1'b1, 1'b0);
    model_byte(8'h29, 1'b0);
    n_chk++; if (fe_cnt - fe0 !== 1) begin n_fail++; $display("FAIL par_ferr: got %0d pulses want 1", fe_cnt - fe0); end
    n_chk++; if (xkey !== 16'hE074) begin n_fail++; $display("FAIL par_xkey: got %h want e074", xkey); end
    send_good(8'hE0);
    send_frame(8'h33, 1'b1, 1'b0);
    model_byte(8'h33, 1'b0);
    send_good(8'h75);
    n_chk++; if (xkey !== 16'h0075) begin n_fail++; $display("FAIL par_prefix: got %h want 0075", xkey); end
    n_chk++; if (key_hold !== 4'b1000) begin n_fail++; $display("FAIL par_hold: got %b want 1000", key_hold); end
  endtask

  task automatic test_timeout;
    logic [10:0] f;
    int fe0 = fe_cnt;
    f = {1'b1, ~^8'h1C, 8'h1C, 1'b0};
    for (int i = 0; i < 5; i++) send_bit(f[i]);
    repeat (Tmo + 10) @(negedge clk);
    model_byte(8'h00, 1'b0);
    n_chk++; if (fe_cnt - fe0 !== 1) begin n_fail++; $display("FAIL tmo_ferr: got %0d pulses want 1", fe_cnt - fe0); end
    send_good(8'h1C);
    n_chk++; if (xkey !== 16'h001C) begin n_fail++; $display("FAIL tmo_next: got %h want 001c", xkey); end
    n_chk++; if (fe_cnt - fe0 !== 1) begin n_fail++; $display("FAIL tmo_extra: got %0d pulses want 1", fe_cnt - fe0); end
  endtask

  task automatic test_glitch_and_clr;
    int kv0 = kv_cnt;
    int fe0 = fe_cnt;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      ps2d = 1'($urandom_range(0, 1));
      ps2c = 1'b0;
      repeat (3) @(negedge clk);
      ps2c = 1'b1;
      ps2d = 1'($urandom_range(0, 1));
      repeat (5) @(negedge clk);
    end
    ps2d = 1'b1;
    repeat (Tmo + 20) @(negedge clk);
    n_chk++; if (kv_cnt !== kv0 || fe_cnt !== fe0) begin
      n_fail++; $display("FAIL glitch_quiet: got kv %0d fe %0d want kv %0d fe %0d", kv_cnt, fe_cnt, kv0, fe0);
    end
    send_good(8'hE0); send_good(8'h6B);
    n_chk++; if (key_hold !== 4'b1100) begin n_fail++; $display("FAIL glitch_next: got %b want 1100", key_hold); end
    // Reset in the middle of a frame.
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    @(negedge clk);
    #2 clr = 1'b1;
    #1;
    n_chk++; if (xkey !== 16'h0 || key_hold !== 4'b0 || key_valid !== 1'b0 || frame_err !== 1'b0) begin
      n_fail++; $display("FAIL clr_async: got xkey %h hold %b kv %b fe %b want all 0", xkey, key_hold, key_valid, frame_err);
    end
    repeat (3) @(negedge clk);
    clr = 1'b0;
    m_ext = 0; m_brk = 0; m_xkey = '0; m_hold = '0;
    repeat (5) @(negedge clk);
    kv0 = kv_cnt;
    send_good(8'h1C);
    n_chk++; if (xkey !== 16'h001C || kv_cnt - kv0 !== 1) begin
      n_fail++; $display("FAIL clr_next: got xkey %h pulses %0d want 001c 1", xkey, kv_cnt - kv0);
    end
    n_chk++; if (key_hold !== 4'b0000) begin n_fail++; $display("FAIL clr_hold: got %b want 0000", key_hold); end
  endtask

  task automatic test_random;
    logic [7:0] pool [8];
    logic [7:0] b;
    bit bad_par, bad_stop;
    int r;
    pool = '{8'hE0, 8'hF0, 8'h75, 8'h72, 8'h6B, 8'h74, 8'h1C, 8'h29};
    for (int n = 0; n < 60; n++) begin
      r = $urandom_range(0, 9);
      b = (r < 8) ? pool[r] : 8'($urandom);
      bad_par  = ($urandom_range(0, 9) == 0);
      bad_stop = !bad_par && ($urandom_range(0, 19) == 0);
      send_frame(b, bad_par, bad_stop);
      model_byte(b, !(bad_par || bad_stop));
      n_chk++; if (xkey !== m_xkey) begin n_fail++; $display("FAIL rnd_xkey[%0d]: got %h want %h", n, xkey, m_xkey); end
      n_chk++; if (key_hold !== m_hold) begin n_fail++; $display("FAIL rnd_hold[%0d]: got %b want %b", n, key_hold, m_hold); end
      n_chk++; if (kv_cnt !== exp_kv) begin n_fail++; $display("FAIL rnd_kv[%0d]: got %0d want %0d", n, kv_cnt, exp_kv); end
      n_chk++; if (fe_cnt !== exp_fe) begin n_fail++; $display("FAIL rnd_ferr[%0d]: got %0d want %0d", n, fe_cnt, exp_fe); end
    end
  endtask

  initial begin
    test_reset();
    test_make();
    test_break();
    test_multi_hold();
    test_parity_err();
    test_timeout();
    test_glitch_and_clr();
    exp_kv = kv_cnt;
    exp_fe = fe_cnt;
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
